// File: rtl/dm_ctrl_pkg.sv
// rtl/dm_ctrl_pkg.sv - shared codes and FSM states for the data-memory arbiter
package dm_ctrl_pkg;

    localparam logic [1:0] SEL_BYTE = 2'b01;
    localparam logic [1:0] SEL_HALF = 2'b10;
    localparam logic [1:0] SEL_WORD = 2'b00;

    localparam int DM_ADDR_HI = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way combinational picker, round-robin or fixed priority
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] grant
);

    // On a tie, the port that did not win last time goes next (last=1 favours port 0).
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (fixed || last) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - shares one data memory between CPU (port 0) and debug/DMA (port 1)
module dm_arbiter
    import dm_ctrl_pkg::*;
#(
    parameter int DM_WORDS   = 3072,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [1:0]  sel0,
    input  logic [31:0] pc0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [1:0]  sel1,
    input  logic [31:0] pc1,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        err0,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic [31:0] dm_a,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    output logic        dm_we,
    output logic [1:0]  dm_sel,
    input  logic [31:0] dm_rd
);

    state_t      state;
    logic        last_winner;
    logic        port_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [1:0]  sel_q;
    logic [31:0] rdata_q;

    logic [1:0]  pick;
    logic [1:0]  grant;
    logic        accept_ok;
    logic        win;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_pc;
    logic [1:0]  w_sel;
    logic        in_access;
    logic        in_resp;

    function automatic logic addr_err(input logic [31:0] addr, input logic [1:0] sel);
        logic is_word;
        logic misaligned;
        logic out_of_range;
        is_word      = (sel != SEL_BYTE) && (sel != SEL_HALF);
        misaligned   = ((sel == SEL_HALF) && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        out_of_range = (addr[31:DM_ADDR_HI] != '0) ||
                       ({20'd0, addr[DM_ADDR_HI-1:2]} >= 32'(DM_WORDS));
        return misaligned || out_of_range;
    endfunction

    rr_arb2 u_pick (
        .req   ({req1, req0}),
        .last  (last_winner),
        .fixed (FIXED_PRIO),
        .grant (pick)
    );

    // ACCESS is the only cycle the DM is busy, so a new grant may overlap RESP.
    assign accept_ok = (state != ST_ACCESS) && !RESET;
    assign grant     = pick & {2{accept_ok}};
    assign gnt0      = grant[0];
    assign gnt1      = grant[1];
    assign win       = grant[1];

    assign w_we    = win ? we1    : we0;
    assign w_addr  = win ? addr1  : addr0;
    assign w_wdata = win ? wdata1 : wdata0;
    assign w_pc    = win ? pc1    : pc0;
    assign w_sel   = win ? sel1   : sel0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            last_winner <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            sel_q       <= '0;
            rdata_q     <= '0;
        end else begin
            if (|grant) begin
                state       <= ST_ACCESS;
                last_winner <= win;
                port_q      <= win;
                we_q        <= w_we;
                err_q       <= addr_err(w_addr, w_sel);
                addr_q      <= w_addr;
                wdata_q     <= w_wdata;
                pc_q        <= w_pc;
                sel_q       <= w_sel;
            end else if (state == ST_ACCESS) begin
                state <= ST_RESP;
            end else if (state == ST_RESP) begin
                state <= ST_IDLE;
            end
            if (state == ST_ACCESS) begin
                rdata_q <= (we_q || err_q) ? 32'd0 : dm_rd;
            end
        end
    end

    assign in_access = (state == ST_ACCESS);
    assign in_resp   = (state == ST_RESP);

    assign dm_a   = in_access ? addr_q  : 32'd0;
    assign dm_wd  = in_access ? wdata_q : 32'd0;
    assign dm_pc  = in_access ? pc_q    : 32'd0;
    assign dm_sel = in_access ? sel_q   : 2'b00;
    assign dm_we  = in_access && we_q && !err_q;

    assign rvalid0 = in_resp && !port_q;
    assign rvalid1 = in_resp && port_q;
    assign rdata0  = rvalid0 ? rdata_q : 32'd0;
    assign rdata1  = rvalid1 ? rdata_q : 32'd0;
    assign err0    = rvalid0 && err_q;
    assign err1    = rvalid1 && err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter with a behavioural DM
module tb_dm_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, pc0, addr1, wdata1, pc1;
    logic [1:0]  sel0, sel1;
    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] dm_a, dm_wd, dm_pc, dm_rd;
    logic        dm_we;
    logic [1:0]  dm_sel;

    logic        f_gnt0, f_rvalid0, f_err0, f_gnt1, f_rvalid1, f_err1;
    logic [31:0] f_rdata0, f_rdata1, f_dm_a, f_dm_wd, f_dm_pc;
    logic        f_dm_we;
    logic [1:0]  f_dm_sel;

    logic [31:0] mem [0:3071];
    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int rv1_cnt = 0;
    int gnt1_cnt = 0;

    always #5 CLK = ~CLK;

    dm_arbiter #(.DM_WORDS(3072), .FIXED_PRIO(1'b0)) dut (
        .CLK(CLK), .RESET(RESET),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .sel0(sel0), .pc0(pc0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .sel1(sel1), .pc1(pc1),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .dm_a(dm_a), .dm_wd(dm_wd), .dm_pc(dm_pc), .dm_we(dm_we), .dm_sel(dm_sel),
        .dm_rd(dm_rd)
    );

    dm_arbiter #(.DM_WORDS(3072), .FIXED_PRIO(1'b1)) u_fix (
        .CLK(CLK), .RESET(RESET),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .sel0(sel0), .pc0(pc0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .sel1(sel1), .pc1(pc1),
        .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0), .err0(f_err0),
        .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1), .err1(f_err1),
        .dm_a(f_dm_a), .dm_wd(f_dm_wd), .dm_pc(f_dm_pc), .dm_we(f_dm_we), .dm_sel(f_dm_sel),
        .dm_rd(32'd0)
    );

    // Behavioural DM: combinational sign-extending read, byte/half/word write on the clock edge
    always_comb begin
        logic [31:0] w;
        w = (dm_a[13:2] < 12'd3072) ? mem[dm_a[13:2]] : 32'd0;
        case (dm_sel)
            2'b01:   dm_rd = {{24{w[8*dm_a[1:0]+7]}}, w[8*dm_a[1:0] +: 8]};
            2'b10:   dm_rd = {{16{w[16*dm_a[1]+15]}}, w[16*dm_a[1] +: 16]};
            default: dm_rd = w;
        endcase
    end

    always @(posedge CLK) begin
        if (dm_we && dm_a[13:2] < 12'd3072) begin
            logic [31:0] w;
            w = mem[dm_a[13:2]];
            case (dm_sel)
                2'b01:   w[8*dm_a[1:0] +: 8]  = dm_wd[7:0];
                2'b10:   w[16*dm_a[1] +: 16]  = dm_wd[15:0];
                default: w = dm_wd;
            endcase
            mem[dm_a[13:2]] <= w;
        end
    end

    always @(negedge CLK) begin
        if (dm_we)   we_cnt++;
        if (rvalid1) rv1_cnt++;
        if (gnt1)    gnt1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sel);
        if (p == 0) begin
            req0 = v; we0 = we; addr0 = addr; wdata0 = wd; sel0 = sel; pc0 = 32'h1000 + addr;
        end else begin
            req1 = v; we1 = we; addr1 = addr; wdata1 = wd; sel1 = sel; pc1 = 32'h2000 + addr;
        end
    endtask

    task automatic wait_gnt(input int p, input string tag);
        logic g;
        g = 1'b0;
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge CLK);
            g = (p == 0) ? gnt0 : gnt1;
        end
        check({tag, "_gnt"}, {31'd0, g}, 32'd1);
    endtask

    task automatic txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sel, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        @(posedge CLK); #1;
        set_req(p, 1'b1, we, addr, wd, sel);
        wait_gnt(p, tag);
        @(posedge CLK); #1;
        set_req(p, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        @(negedge CLK);
        check({tag, "_rv_access"}, {31'd0, (p == 0) ? rvalid0 : rvalid1}, 32'd0);
        @(negedge CLK);
        check({tag, "_rvalid"}, {31'd0, (p == 0) ? rvalid0 : rvalid1}, 32'd1);
        check({tag, "_rdata"}, (p == 0) ? rdata0 : rdata1, exp_rd);
        check({tag, "_err"}, {31'd0, (p == 0) ? err0 : err1}, {31'd0, exp_err});
    endtask

    initial begin
        int w0, g1, r1;
        RESET = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'b00);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        for (int i = 0; i < 3072; i++) mem[i] = 32'd0;
        mem[4]    = 32'h8000_00F1;
        mem[3071] = 32'h1234_5678;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_dm_a", dm_a, 32'd0);
        @(posedge CLK); #1;
        req0 = 1'b0;
        RESET = 1'b0;

        txn(0, 1'b0, 32'h10, 32'd0, 2'b00, 32'h8000_00F1, 1'b0, "lw0");
        w0 = we_cnt;
        txn(1, 1'b1, 32'h13, 32'hAB, 2'b01, 32'd0, 1'b0, "sb1");
        check("sb1_we_cycles", we_cnt, w0 + 1);
        check("sb1_mem", mem[4], 32'hAB00_00F1);
        txn(1, 1'b0, 32'h13, 32'd0, 2'b01, 32'hFFFF_FFAB, 1'b0, "lb1");
        txn(0, 1'b0, 32'h12, 32'd0, 2'b10, 32'hFFFF_AB00, 1'b0, "lh0");

        w0 = we_cnt;
        txn(0, 1'b1, 32'h21, 32'h1234, 2'b10, 32'd0, 1'b1, "sh_mis");
        txn(1, 1'b0, 32'h22, 32'd0, 2'b00, 32'd0, 1'b1, "lw_mis");
        txn(0, 1'b0, 32'h4000, 32'd0, 2'b00, 32'd0, 1'b1, "lw_oor");
        txn(1, 1'b0, 32'h3000, 32'd0, 2'b11, 32'd0, 1'b1, "lw_top");
        check("err_no_write", we_cnt, w0);
        txn(0, 1'b0, 32'h2FFC, 32'd0, 2'b00, 32'h1234_5678, 1'b0, "lw_last");

        // Contention from reset: RR alternates 0,1 on every other cycle; fixed priority keeps port 0
        @(posedge CLK); #1;
        RESET = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'b00);
        set_req(1, 1'b1, 1'b0, 32'h10, 32'd0, 2'b00);
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check($sformatf("rr_gnt0_c%0d", k), {31'd0, gnt0}, {31'd0, (k % 4) == 0});
            check($sformatf("rr_gnt1_c%0d", k), {31'd0, gnt1}, {31'd0, (k % 4) == 2});
            check($sformatf("fix_gnt0_c%0d", k), {31'd0, f_gnt0}, {31'd0, (k % 2) == 0});
            check($sformatf("fix_gnt1_c%0d", k), {31'd0, f_gnt1}, 32'd0);
        end
        @(posedge CLK); #1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        repeat (4) @(posedge CLK);

        // Reset arriving in the ACCESS cycle of a store
        #1;
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b00);
        wait_gnt(0, "rst_st");
        @(posedge CLK); #1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        #2;
        check("rst_st_we_before", {31'd0, dm_we}, 32'd1);
        RESET = 1'b1;
        #1;
        check("rst_st_we_after", {31'd0, dm_we}, 32'd0);
        check("rst_st_dm_a", dm_a, 32'd0);
        @(negedge CLK);
        check("rst_st_rv_a", {31'd0, rvalid0}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_st_rv_b", {31'd0, rvalid0}, 32'd0);
        check("rst_st_mem", mem[4], 32'hAB00_00F1);
        txn(0, 1'b0, 32'h10, 32'd0, 2'b00, 32'hAB00_00F1, 1'b0, "lw_after_rst");

        // Port 1 raises req only during port 0's ACCESS cycle and then withdraws
        g1 = gnt1_cnt;
        r1 = rv1_cnt;
        @(posedge CLK); #1;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'b00);
        wait_gnt(0, "wd");
        @(posedge CLK); #1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        set_req(1, 1'b1, 1'b0, 32'h10, 32'd0, 2'b00);
        @(negedge CLK);
        check("wd_gnt1_access", {31'd0, gnt1}, 32'd0);
        @(posedge CLK); #1;
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        @(negedge CLK);
        check("wd_rvalid0", {31'd0, rvalid0}, 32'd1);
        check("wd_rdata0", rdata0, 32'hAB00_00F1);
        repeat (3) @(negedge CLK);
        check("wd_no_gnt1", gnt1_cnt, g1);
        check("wd_no_rvalid1", rv1_cnt, r1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
